pll_phase_stepper: RTL and testbench

PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

---
 rtl/pll_phase_pkg.sv | 28 ++
 rtl/pll_phase_stepper.sv | 148 ++++++++++++++
 tb/tb_pll_phase_stepper.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_pkg.sv
// rtl/pll_phase_pkg.sv - shared state encoding, defaults and timer helper for the PLL phase stepper
package pll_phase_pkg;

   // Default timing, in clk cycles
   localparam int unsigned SETUP_CYCLES_DEF = 4;
   localparam int unsigned PULSE_CYCLES_DEF = 4;
   localparam int unsigned GAP_CYCLES_DEF   = 8;
   localparam int unsigned LOCK_TIMEOUT_DEF = 1024;

   localparam int TIMER_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_PULSE    = 3'd2,
      ST_GAP      = 3'd3,
      ST_LOCKWAIT = 3'd4
   } step_state_t;

   // The timer is loaded on state entry and the state is left on the edge
   // that sees it at zero, so an N-cycle state loads N-1. Zero-length
   // settings collapse to a single cycle.
   function automatic logic [TIMER_W-1:0] timer_load(input int unsigned cycles);
      if (cycles <= 1) return '0;
      return TIMER_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/pll_phase_stepper.sv
// rtl/pll_phase_stepper.sv - sequences PHASESEL/PHASEDIR/PHASESTEP pulses into a PLL and waits for relock
module pll_phase_stepper
   import pll_phase_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF,
   parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DEF,
   parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF,
   parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_sel,
   input  logic       req_dir,
   input  logic [7:0] req_count,
   output logic [1:0] pll_phasesel,
   output logic       pll_phasedir,
   output logic       pll_phasestep,
   output logic       pll_phaseloadreg,
   input  logic       pll_locked,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [7:0] steps_done
);

   localparam logic [TIMER_W-1:0] SETUP_LOAD = timer_load(SETUP_CYCLES);
   localparam logic [TIMER_W-1:0] PULSE_LOAD = timer_load(PULSE_CYCLES);
   localparam logic [TIMER_W-1:0] GAP_LOAD   = timer_load(GAP_CYCLES);
   localparam logic [TIMER_W-1:0] LOCK_LOAD  = timer_load(LOCK_TIMEOUT);

   step_state_t        state;
   logic [TIMER_W-1:0] timer;
   logic [7:0]         count_q;
   logic               lock_meta;
   logic               lock_sync;
   logic               last_step;

   // The load register is never used; the PLL keeps its internal phase setting
   assign pll_phaseloadreg = 1'b1;

   // True when the pulse now ending is the last one the request asked for
   assign last_step = ({1'b0, steps_done} + 9'd1) >= {1'b0, count_q};

   // Sequencer: state, timer, lock synchroniser and all registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         timer         <= '0;
         count_q       <= '0;
         lock_meta     <= 1'b0;
         lock_sync     <= 1'b0;
         req_ready     <= 1'b0;
         pll_phasesel  <= 2'd0;
         pll_phasedir  <= 1'b0;
         pll_phasestep <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         steps_done    <= 8'd0;
      end else begin
         done      <= 1'b0;
         lock_meta <= pll_locked;
         lock_sync <= lock_meta;
         if (timer != '0) timer <= timer - 16'd1;

         case (state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready    <= 1'b0;
                  pll_phasesel <= req_sel;
                  pll_phasedir <= req_dir;
                  count_q      <= req_count;
                  steps_done   <= 8'd0;
                  error        <= 1'b0;
                  busy         <= 1'b1;
                  if (req_count == 8'd0) begin
                     // Nothing to step: go straight to judging lock.
                     // The synchroniser restarts so lock is judged only
                     // from samples taken inside LOCKWAIT.
                     state     <= ST_LOCKWAIT;
                     timer     <= LOCK_LOAD;
                     lock_meta <= 1'b0;
                     lock_sync <= 1'b0;
                  end else begin
                     state <= ST_SETUP;
                     timer <= SETUP_LOAD;
                  end
               end
            end

            ST_SETUP: begin
               if (timer == '0) begin
                  state         <= ST_PULSE;
                  timer         <= PULSE_LOAD;
                  pll_phasestep <= 1'b0;
               end
            end

            ST_PULSE: begin
               if (timer == '0) begin
                  pll_phasestep <= 1'b1;
                  if (steps_done != count_q) steps_done <= steps_done + 8'd1;
                  if (last_step) begin
                     state     <= ST_LOCKWAIT;
                     timer     <= LOCK_LOAD;
                     lock_meta <= 1'b0;
                     lock_sync <= 1'b0;
                  end else begin
                     state <= ST_GAP;
                     timer <= GAP_LOAD;
                  end
               end
            end

            ST_GAP: begin
               // Lock is deliberately ignored here: the PLL may unlock
               // briefly after each step.
               if (timer == '0) begin
                  state         <= ST_PULSE;
                  timer         <= PULSE_LOAD;
                  pll_phasestep <= 1'b0;
               end
            end

            ST_LOCKWAIT: begin
               if (lock_sync || timer == '0) begin
                  error     <= ~lock_sync;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state         <= ST_IDLE;
               pll_phasestep <= 1'b1;
               busy          <= 1'b0;
               req_ready     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb/tb_pll_phase_stepper.sv - randomized self-checking bench for pll_phase_stepper
module tb_pll_phase_stepper;

   localparam int S = 4;
   localparam int P = 4;
   localparam int G = 8;
   localparam int T = 1024;
   localparam int LOCK_DEPTH = 8192;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_sel = 2'd0;
   logic       req_dir = 1'b0;
   logic [7:0] req_count = 8'd0;
   logic [1:0] pll_phasesel;
   logic       pll_phasedir;
   logic       pll_phasestep;
   logic       pll_phaseloadreg;
   logic       pll_locked = 1'b0;
   logic       busy;
   logic       done;
   logic       error;
   logic [7:0] steps_done;

   int n_checks = 0;
   int n_errors = 0;
   bit lock_arr [0:LOCK_DEPTH-1];

   pll_phase_stepper dut (
      .clk              (clk),
      .resetn           (resetn),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_sel          (req_sel),
      .req_dir          (req_dir),
      .req_count        (req_count),
      .pll_phasesel     (pll_phasesel),
      .pll_phasedir     (pll_phasedir),
      .pll_phasestep    (pll_phasestep),
      .pll_phaseloadreg (pll_phaseloadreg),
      .pll_locked       (pll_locked),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .steps_done       (steps_done)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ps"},    pll_phasestep, 1);
      chk({tag, "_load"},  pll_phaseloadreg, 1);
      chk({tag, "_sel"},   pll_phasesel, 0);
      chk({tag, "_dir"},   pll_phasedir, 0);
      chk({tag, "_rdy"},   req_ready, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_err"},   error, 0);
      chk({tag, "_steps"}, steps_done, 0);
   endtask

   // Lock level present at each clock edge, indexed from the accept edge (0).
   // mode 0: always locked; 1: dropout window before LOCKWAIT;
   // 2: lost from the first pulse onward; 3: locks late, inside LOCKWAIT.
   task automatic build_lock(input int mode, input int l);
      int a, b, r;
      for (int k = 0; k < LOCK_DEPTH; k++) lock_arr[k] = 1'b1;
      case (mode)
         1: if (l >= 2) begin
               a = $urandom_range(1, l - 1);
               b = $urandom_range(a, l);
               for (int k = a; k < b; k++) lock_arr[k] = 1'b0;
            end
         2: for (int k = (l >= S ? S : 0); k < LOCK_DEPTH; k++) lock_arr[k] = 1'b0;
         3: begin
               r = $urandom_range(0, 40);
               for (int k = 0; k <= l + r; k++) lock_arr[k] = 1'b0;
            end
         default: ;
      endcase
   endtask

   // The sequencer sees lock two edges late and only after its own restart at
   // LOCKWAIT entry, so the first edge that can finish is l+3.
   function automatic int exp_done_edge(input int l, output bit err);
      for (int t = l + 3; t <= l + T; t++) begin
         if (lock_arr[t-2]) begin
            err = 1'b0;
            return t;
         end
      end
      err = 1'b1;
      return l + T;
   endfunction

   task automatic run_req(input logic [1:0] sel, input logic dir, input logic [7:0] cnt,
                          input int mode, input bit junk, input int abort_at);
      int  l, td, off, exp_sd, first_done, first_fall, falls, waited;
      int  bad_ps, bad_hold, bad_hs, bad_sd, bad_err;
      bit  err_exp, exp_low, prev_ps;

      l = (cnt == 0) ? 0 : S + int'(cnt) * P + (int'(cnt) - 1) * G;
      build_lock(mode, l);
      td = exp_done_edge(l, err_exp);

      @(negedge clk);
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_wait", req_ready, 1);

      req_valid  = 1'b1;
      req_sel    = sel;
      req_dir    = dir;
      req_count  = cnt;
      pll_locked = lock_arr[0];

      first_done = -1;
      first_fall = -1;
      falls      = 0;
      prev_ps    = 1'b1;
      bad_ps = 0; bad_hold = 0; bad_hs = 0; bad_sd = 0; bad_err = 0;

      for (int k = 0; k <= td + 1; k++) begin
         @(posedge clk);
         @(negedge clk);

         exp_low = 1'b0;
         if (k >= S) begin
            off = k - S;
            exp_low = (off / (P + G) < int'(cnt)) && (off % (P + G) < P);
         end
         exp_sd = 0;
         if (k >= S + P) begin
            exp_sd = (k - S - P) / (P + G) + 1;
            if (exp_sd > int'(cnt)) exp_sd = int'(cnt);
         end

         if (k == abort_at) begin
            chk("pre_rst_ps", pll_phasestep, 0);
            #2 resetn = 1'b0;
            #1 chk_reset_outputs("rst_mid");
            req_valid = 1'b0;
            repeat (2) @(negedge clk);
            chk_reset_outputs("rst_hold");
            resetn = 1'b1;
            #1 chk("rdy_at_release", req_ready, 0);
            @(posedge clk);
            #1 chk("rdy_one_edge", req_ready, 1);
            chk("ps_after_rst", pll_phasestep, 1);
            return;
         end

         if (pll_phasestep !== !exp_low) bad_ps++;
         if (pll_phasesel !== sel || pll_phasedir !== dir) bad_hold++;
         if (busy !== (k < td) || req_ready !== (k >= td) || done !== (k == td)) bad_hs++;
         if (steps_done !== 8'(exp_sd)) bad_sd++;
         if (error !== ((k >= td) ? err_exp : 1'b0)) bad_err++;
         if (prev_ps && !pll_phasestep) begin
            falls++;
            if (first_fall < 0) first_fall = k;
         end
         prev_ps = pll_phasestep;
         if (done && first_done < 0) first_done = k;

         if (junk && k + 1 < td) begin
            req_valid = 1'($urandom_range(0, 1));
            req_sel   = 2'($urandom);
            req_dir   = 1'($urandom);
            req_count = 8'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         pll_locked = lock_arr[k+1];
      end

      chk("ps_wave", bad_ps, 0);
      chk("sel_dir_hold", bad_hold, 0);
      chk("handshake", bad_hs, 0);
      chk("steps_track", bad_sd, 0);
      chk("error_track", bad_err, 0);
      chk("pulses", falls, int'(cnt));
      chk("first_fall", first_fall, (cnt == 0) ? -1 : S);
      chk("done_at", first_done, td);
      chk("steps_final", steps_done, int'(cnt));
      chk("error_final", error, int'(err_exp));
   endtask

   initial begin
      int m, mode;

      #12;
      chk_reset_outputs("por");
      @(negedge clk);
      resetn = 1'b1;
      #1 chk("por_rdy_release", req_ready, 0);
      @(posedge clk);
      #1 chk("por_rdy_edge", req_ready, 1);

      run_req(2'd1, 1'b1, 8'd3, 0, 1'b0, -1);
      run_req(2'd2, 1'b0, 8'd0, 0, 1'b0, -1);
      run_req(2'd3, 1'b1, 8'd2, 2, 1'b0, -1);
      run_req(2'd0, 1'b0, 8'd1, 0, 1'b0, -1);
      run_req(2'd2, 1'b1, 8'd3, 1, 1'b0, -1);
      run_req(2'd1, 1'b0, 8'd4, 0, 1'b1, -1);

      for (int i = 0; i < 12; i++) begin
         m = $urandom_range(0, 9);
         mode = (m < 5) ? 0 : (m < 7) ? 1 : (m < 9) ? 3 : 2;
         run_req(2'($urandom), 1'($urandom), 8'($urandom_range(0, 6)), mode,
                 1'($urandom_range(0, 1)), -1);
      end

      run_req(2'd3, 1'b1, 8'd255, 0, 1'b1, -1);

      run_req(2'd2, 1'b1, 8'd5, 0, 1'b0, S + (P + G) + 1);
      run_req(2'd1, 1'b1, 8'd2, 0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
